dplca_node_ctrl: RTL
====================

// Module: dplca_node_ctrl
// PURPOSE
//  Parametrised synchronous D-PLCA node control state machine (Clause 148.8 successor).
//  Elects coordinator or follower role and owns the local_nodeID and plca_node_count registers as outputs.
//  Runs the wait_beacon and beacon_timeout timers internally; a claim-table scan sub-module supplies claim data.
//  Sits between the PLCA control/data FSMs (tx_cmd/rx_cmd, plca_status) and the TXOP claim-table aging logic.
// PARAMETERS
//  NODE_W            8      width of node ID / node count; claim table is 2**NODE_W bits
//  MIN_NODE_COUNT    8      floor for plca_node_count; also the WAIT_BEACON initial value
//  WAIT_BEACON_CYC   20000  clk cycles for wait_beacon_timer
//  BEACON_TO_CYC     400    clk cycles for beacon_timeout_timer
// PORTS
//  clk                    in   1         single clock
//  plca_reset_n           in   1         asynchronous, active-low reset
//  dplca_en, plca_en      in   1 each    enables; either low forces DISABLED
//  coordinator_role_allowed in 1         permits COORDINATOR role
//  plca_status            in   1         1=OK, 0=FAIL
//  tx_cmd, rx_cmd         in   2 each    00 BEACON, 01 COMMIT, 10 NONE
//  dplca_txop_table_upd   in   1         one-cycle pulse: claim table updated
//  dplca_new_age          in   1         level: new aging cycle in progress
//  dplca_txop_id          in   NODE_W    TXOP ID of last update
//  dplca_txop_node_count  in   NODE_W    node count advertised in last update
//  txop_claim_table       in   2**NODE_W bit i = TXOP i claimed
//  state                  out  4         current state encoding (dplca_pkg)
//  dplca_aging            out  1         aging enable
//  local_node_id          out  NODE_W    local TXOP ID
//  plca_node_count        out  NODE_W    node count used by PLCA control
//  pick_fail              out  1         FOLLOWER found no free TXOP
// BEHAVIOUR
//  Reset: state=DISABLED, dplca_aging=0, local_node_id=2**NODE_W-2, plca_node_count=MIN_NODE_COUNT, pick_fail=0, timers idle.
//  Registered FSM: one transition per clk; state-entry actions take effect on the entry edge.
//  Override (highest priority): !dplca_en | !plca_en -> DISABLED on the next edge, from any state.
//  DISABLED: aging=0, wait_beacon timer (re)started; next cycle -> WAIT_BEACON.
//  WAIT_BEACON: entry sets local_node_id=2**NODE_W-2, node_count=MIN_NODE_COUNT.
//    Priority: status OK -> LEARNING; else timer done & allowed -> COORDINATOR; else timer done -> DISABLED.
//  COORDINATOR: entry sets local_node_id=0, aging=1.
//    Let C0=table[0], CL=table[node_count-1], U=table_upd, A=new_age, RB=(rx_cmd==BEACON). Priority:
//    1) !C0 & !RB & U & CL & A & count<2**NODE_W-1 -> INCREASE_NODE_COUNT
//    2) (U & C0) | RB -> LEARNING
//    3) tx_cmd==BEACON -> LOOPBACK_TX
//    4) !C0 & !RB & U & !CL & A & count>MIN_NODE_COUNT -> REDUCE_NODE_COUNT
//  REDUCE_NODE_COUNT: entry sets count=max(MAX_CLAIM+2, MIN_NODE_COUNT), saturating at 2**NODE_W-1;
//    MAX_CLAIM is the highest set table index, 0 if none. !new_age -> COORDINATOR.
//  INCREASE_NODE_COUNT: entry sets count+1 (count never exceeds 2**NODE_W-1). !new_age -> COORDINATOR.
//  LOOPBACK_TX: entry starts beacon_timeout. Timeout beats RB: timer done -> DISABLED; else RB -> LOOPBACK_RX.
//  LOOPBACK_RX: rx_cmd!=BEACON -> COORDINATOR.
//  LEARNING: entry sets local_node_id=2**NODE_W-2, aging=1.
//    U & A & OK -> FOLLOWER; FAIL -> DISABLED.
//  FOLLOWER: FAIL -> DISABLED. Re-pick trigger (U & OK &
//    (table[local_node_id] | (txop_id==0 & txop_node_count<=local_node_id) | (A & local_node_id>MAX_CLAIM))):
//    stay in FOLLOWER and re-run the entry action.
//    Entry action: local_node_id = lowest unclaimed i in [1, count-1]. If none, local_node_id=2**NODE_W-2 and pick_fail=1.
//    Any successful pick clears pick_fail.
//  Timers: down-counters that reload on start; done is a level held until the next start. Restart mid-count reloads.
//  Reset asserted mid-operation: every output returns to its reset value asynchronously.
// CONFIGURATION
//  DPLCA_STATS_EN defined: adds outputs coord_entries, follower_repicks, loopback_timeouts (16 bits each).
//    Each counter saturates at 0xFFFF and clears on reset or DISABLED entry.
//  DPLCA_STATS_EN undefined: those ports and counters do not exist; FSM behaviour is identical.
// STRUCTURE
//  dplca_pkg: state enum (DISABLED=0 .. FOLLOWER=8), CMD_BEACON/COMMIT/NONE, STATUS_OK/FAIL.
//  Sub-module dplca_claim_scan: combinational; outputs max_claim, first_free, free_found, claim_at_idx(index).
// TESTING
//  T1 status OK during WAIT_BEACON -> LEARNING; then upd & new_age -> FOLLOWER; table bits 1,2 set, count=8 -> local_node_id=3.
//  T2 status FAIL, allowed=1, WAIT_BEACON_CYC elapse -> COORDINATOR, local_node_id=0, aging=1;
//     tx_cmd=BEACON -> LOOPBACK_TX; rx BEACON -> LOOPBACK_RX; rx NONE -> COORDINATOR.
//  T3 COORDINATOR, count=8, table[7]=1, upd & new_age -> count=9; new_age=0 -> COORDINATOR.
//  T4 COORDINATOR, count=20, max claim 5, upd & new_age -> count=8 (clamped from 7).
//  T5 LOOPBACK_TX with no rx BEACON for BEACON_TO_CYC -> DISABLED; with STATS, loopback_timeouts=1.
//  T6 FOLLOWER local_node_id=3, table[3] set by upd -> repick 4; table 1..7 all set -> pick_fail=1, id=254.
//     plca_en low in any state -> DISABLED.

Source files
------------

// File: rtl/dplca_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : dplca_pkg                                                     |
// | Purpose    : Shared types and constants for the D-PLCA node controller:   |
// |              FSM state encoding, PLCA command codes, status codes and a    |
// |              saturating statistics-counter helper.                        |
// | Ports      : none (package)                                                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package dplca_pkg;

  // Node controller states; the numeric values are visible on the state port.
  typedef enum logic [3:0] {
    ST_DISABLED            = 4'd0,
    ST_WAIT_BEACON         = 4'd1,
    ST_COORDINATOR         = 4'd2,
    ST_REDUCE_NODE_COUNT   = 4'd3,
    ST_INCREASE_NODE_COUNT = 4'd4,
    ST_LOOPBACK_TX         = 4'd5,
    ST_LOOPBACK_RX         = 4'd6,
    ST_LEARNING            = 4'd7,
    ST_FOLLOWER            = 4'd8
  } dplca_state_e;

  // tx_cmd / rx_cmd encodings from the PLCA control FSM
  localparam logic [1:0] CMD_BEACON = 2'b00;
  localparam logic [1:0] CMD_COMMIT = 2'b01;
  localparam logic [1:0] CMD_NONE   = 2'b10;

  // plca_status encodings
  localparam logic STATUS_OK   = 1'b1;
  localparam logic STATUS_FAIL = 1'b0;

  // Next value of a 16-bit statistics counter. A clear still records an
  // event landing on the same edge, so the event that caused the clear
  // (e.g. a loopback timeout dropping into DISABLED) is not lost.
  function automatic logic [15:0] stat_next(input logic [15:0] cur,
                                            input logic        clr,
                                            input logic        evt);
    logic [15:0] nxt;
    if (clr) begin
      nxt = {15'd0, evt};
    end else if (evt && (cur != 16'hFFFF)) begin
      nxt = cur + 16'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dplca_claim_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dplca_claim_scan                                              |
// | Purpose    : Combinational scan of the TXOP claim table.                   |
// |   claim_table  in   2**NODE_W  bit i = TXOP i claimed                      |
// |   node_count   in   NODE_W     current node count (free-ID search bound)   |
// |   index        in   NODE_W     index for claim_at_idx                      |
// |   max_claim    out  NODE_W     highest claimed index, 0 if none            |
// |   first_free   out  NODE_W     lowest unclaimed i in [1, node_count-1]     |
// |   free_found   out  1          first_free is valid                         |
// |   claim_at_idx out  1          claim_table[index]                          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dplca_claim_scan #(
  parameter int NODE_W = 8
) (
  input  logic [(2**NODE_W)-1:0] claim_table,
  input  logic [NODE_W-1:0]      node_count,
  input  logic [NODE_W-1:0]      index,
  output logic [NODE_W-1:0]      max_claim,
  output logic [NODE_W-1:0]      first_free,
  output logic                   free_found,
  output logic                   claim_at_idx
);

  localparam int TBL_SIZE = 2**NODE_W;

  // Ascending scan: the last hit is the highest claimed index.
  always_comb begin
    max_claim = '0;
    for (int i = 0; i < TBL_SIZE; i++) begin
      if (claim_table[i]) begin
        max_claim = NODE_W'(i);
      end
    end
  end

  // Descending scan: the last hit is the lowest free index. Index 0 is the
  // coordinator's slot and is never offered to a follower.
  always_comb begin
    first_free = '0;
    free_found = 1'b0;
    for (int i = TBL_SIZE - 1; i >= 1; i--) begin
      if ((i < int'(node_count)) && !claim_table[i]) begin
        first_free = NODE_W'(i);
        free_found = 1'b1;
      end
    end
  end

  assign claim_at_idx = claim_table[index];

endmodule
`default_nettype wire

// File: rtl/dplca_node_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dplca_node_ctrl                                               |
// | Purpose    : D-PLCA node control FSM. Elects coordinator/follower role,    |
// |              owns local_node_id and plca_node_count, runs the wait_beacon  |
// |              and beacon_timeout timers.                                    |
// | Ports      :                                                               |
// |   clk, plca_reset_n (async, active-low)                                    |
// |   dplca_en, plca_en, coordinator_role_allowed, plca_status (1=OK)          |
// |   tx_cmd, rx_cmd (00 BEACON, 01 COMMIT, 10 NONE)                           |
// |   dplca_txop_table_upd, dplca_new_age, dplca_txop_id,                      |
// |   dplca_txop_node_count, txop_claim_table                                  |
// |   state, dplca_aging, local_node_id, plca_node_count, pick_fail            |
// | Config     : DPLCA_STATS_EN adds coord_entries, follower_repicks and       |
// |              loopback_timeouts (16-bit saturating counters).               |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dplca_node_ctrl #(
  parameter int NODE_W          = 8,
  parameter int MIN_NODE_COUNT  = 8,
  parameter int WAIT_BEACON_CYC = 20000,
  parameter int BEACON_TO_CYC   = 400
) (
  input  logic                   clk,
  input  logic                   plca_reset_n,
  input  logic                   dplca_en,
  input  logic                   plca_en,
  input  logic                   coordinator_role_allowed,
  input  logic                   plca_status,
  input  logic [1:0]             tx_cmd,
  input  logic [1:0]             rx_cmd,
  input  logic                   dplca_txop_table_upd,
  input  logic                   dplca_new_age,
  input  logic [NODE_W-1:0]      dplca_txop_id,
  input  logic [NODE_W-1:0]      dplca_txop_node_count,
  input  logic [(2**NODE_W)-1:0] txop_claim_table,
  output logic [3:0]             state,
  output logic                   dplca_aging,
  output logic [NODE_W-1:0]      local_node_id,
  output logic [NODE_W-1:0]      plca_node_count,
  output logic                   pick_fail
`ifdef DPLCA_STATS_EN
  ,
  output logic [15:0]            coord_entries,
  output logic [15:0]            follower_repicks,
  output logic [15:0]            loopback_timeouts
`endif
);

  import dplca_pkg::*;

  localparam int                TBL_SIZE      = 2**NODE_W;
  localparam logic [NODE_W-1:0] ID_UNASSIGNED = NODE_W'(TBL_SIZE - 2);
  localparam logic [NODE_W-1:0] COUNT_MAX     = NODE_W'(TBL_SIZE - 1);
  localparam logic [NODE_W-1:0] COUNT_MIN     = NODE_W'(MIN_NODE_COUNT);
  localparam int                WB_W          = $clog2(WAIT_BEACON_CYC + 1);
  localparam int                BT_W          = $clog2(BEACON_TO_CYC + 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  dplca_state_e      state_q, state_d;
  logic              aging_q, aging_d;
  logic [NODE_W-1:0] local_node_id_q, local_node_id_d;
  logic [NODE_W-1:0] node_count_q, node_count_d;
  logic              pick_fail_q, pick_fail_d;
  logic [WB_W-1:0]   wb_cnt_q, wb_cnt_d;
  logic              wb_armed_q, wb_armed_d;
  logic [BT_W-1:0]   bt_cnt_q, bt_cnt_d;
  logic              bt_armed_q, bt_armed_d;

  // ---------------------------------------------------------------------------
  // Claim-table scan
  // ---------------------------------------------------------------------------
  logic [NODE_W-1:0] max_claim;
  logic [NODE_W-1:0] first_free;
  logic              free_found;
  logic              claim_at_local;

  dplca_claim_scan #(
    .NODE_W (NODE_W)
  ) u_claim_scan (
    .claim_table  (txop_claim_table),
    .node_count   (node_count_q),
    .index        (local_node_id_q),
    .max_claim    (max_claim),
    .first_free   (first_free),
    .free_found   (free_found),
    .claim_at_idx (claim_at_local)
  );

  // ---------------------------------------------------------------------------
  // Decoded conditions
  // ---------------------------------------------------------------------------
  logic enabled, status_ok, upd, new_age, rx_beacon, tx_beacon;
  logic claim0, claim_last, grow, shrink, repick_trig;
  logic wb_done, bt_done;
  logic [NODE_W:0]   reduce_raw;
  logic [NODE_W-1:0] reduce_count;
  logic [NODE_W-1:0] inc_count;

  assign enabled    = dplca_en && plca_en;
  assign status_ok  = (plca_status == STATUS_OK);
  assign upd        = dplca_txop_table_upd;
  assign new_age    = dplca_new_age;
  assign rx_beacon  = (rx_cmd == CMD_BEACON);
  assign tx_beacon  = (tx_cmd == CMD_BEACON);
  assign claim0     = txop_claim_table[0];
  assign claim_last = txop_claim_table[node_count_q - NODE_W'(1)];

  // Highest TXOP claimed during the aging cycle: grow if the last slot is in
  // use, shrink if it is not. Neither applies while someone holds TXOP 0 or
  // a beacon is being received (that is a competing coordinator).
  assign grow   = !claim0 && !rx_beacon && upd &&  claim_last && new_age &&
                  (node_count_q < COUNT_MAX);
  assign shrink = !claim0 && !rx_beacon && upd && !claim_last && new_age &&
                  (node_count_q > COUNT_MIN);

  // A follower re-picks when its slot is taken, when the coordinator
  // advertises a count that excludes it, or when its ID lies above every
  // live claim of a fresh aging cycle.
  assign repick_trig = upd && status_ok &&
                       (claim_at_local ||
                        ((dplca_txop_id == '0) && (dplca_txop_node_count <= local_node_id_q)) ||
                        (new_age && (local_node_id_q > max_claim)));

  assign reduce_raw = {1'b0, max_claim} + (NODE_W + 1)'(2);

  always_comb begin
    if (reduce_raw > {1'b0, COUNT_MAX}) begin
      reduce_count = COUNT_MAX;
    end else if (reduce_raw < {1'b0, COUNT_MIN}) begin
      reduce_count = COUNT_MIN;
    end else begin
      reduce_count = reduce_raw[NODE_W-1:0];
    end
  end

  assign inc_count = (node_count_q == COUNT_MAX) ? COUNT_MAX : node_count_q + NODE_W'(1);

  // ---------------------------------------------------------------------------
  // Next state and state-entry actions
  // ---------------------------------------------------------------------------
  logic repick;
  logic entering;

  always_comb begin
    state_d         = state_q;
    aging_d         = aging_q;
    local_node_id_d = local_node_id_q;
    node_count_d    = node_count_q;
    pick_fail_d     = pick_fail_q;
    repick          = 1'b0;
    entering        = 1'b0;

    if (!enabled) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d = ST_WAIT_BEACON;
        end
        ST_WAIT_BEACON: begin
          if (status_ok) begin
            state_d = ST_LEARNING;
          end else if (wb_done && coordinator_role_allowed) begin
            state_d = ST_COORDINATOR;
          end else if (wb_done) begin
            state_d = ST_DISABLED;
          end
        end
        ST_COORDINATOR: begin
          if (grow) begin
            state_d = ST_INCREASE_NODE_COUNT;
          end else if ((upd && claim0) || rx_beacon) begin
            state_d = ST_LEARNING;
          end else if (tx_beacon) begin
            state_d = ST_LOOPBACK_TX;
          end else if (shrink) begin
            state_d = ST_REDUCE_NODE_COUNT;
          end
        end
        ST_REDUCE_NODE_COUNT,
        ST_INCREASE_NODE_COUNT: begin
          if (!new_age) begin
            state_d = ST_COORDINATOR;
          end
        end
        ST_LOOPBACK_TX: begin
          if (bt_done) begin
            state_d = ST_DISABLED;
          end else if (rx_beacon) begin
            state_d = ST_LOOPBACK_RX;
          end
        end
        ST_LOOPBACK_RX: begin
          if (!rx_beacon) begin
            state_d = ST_COORDINATOR;
          end
        end
        ST_LEARNING: begin
          if (upd && new_age && status_ok) begin
            state_d = ST_FOLLOWER;
          end else if (!status_ok) begin
            state_d = ST_DISABLED;
          end
        end
        ST_FOLLOWER: begin
          if (!status_ok) begin
            state_d = ST_DISABLED;
          end else if (repick_trig) begin
            repick = 1'b1;
          end
        end
        default: begin
          state_d = ST_DISABLED;
        end
      endcase
    end

    // Entry actions land on the same edge as the transition; a follower
    // re-pick counts as re-entering FOLLOWER.
    entering = (state_d != state_q) || repick;
    if (entering) begin
      case (state_d)
        ST_DISABLED: begin
          aging_d = 1'b0;
        end
        ST_WAIT_BEACON: begin
          local_node_id_d = ID_UNASSIGNED;
          node_count_d    = COUNT_MIN;
        end
        ST_COORDINATOR: begin
          local_node_id_d = '0;
          aging_d         = 1'b1;
        end
        ST_REDUCE_NODE_COUNT: begin
          node_count_d = reduce_count;
        end
        ST_INCREASE_NODE_COUNT: begin
          node_count_d = inc_count;
        end
        ST_LEARNING: begin
          local_node_id_d = ID_UNASSIGNED;
          aging_d         = 1'b1;
        end
        ST_FOLLOWER: begin
          if (free_found) begin
            local_node_id_d = first_free;
            pick_fail_d     = 1'b0;
          end else begin
            local_node_id_d = ID_UNASSIGNED;
            pick_fail_d     = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Timers: reload on start, count down, done held at zero until next start.
  // wait_beacon is held in reload for as long as the node sits in DISABLED.
  // ---------------------------------------------------------------------------
  logic wb_start, bt_start;

  assign wb_start = (state_q == ST_DISABLED);
  assign bt_start = entering && (state_d == ST_LOOPBACK_TX);
  assign wb_done  = wb_armed_q && (wb_cnt_q == '0);
  assign bt_done  = bt_armed_q && (bt_cnt_q == '0);

  always_comb begin
    wb_cnt_d   = wb_cnt_q;
    wb_armed_d = wb_armed_q;
    if (wb_start) begin
      wb_cnt_d   = WB_W'(WAIT_BEACON_CYC);
      wb_armed_d = 1'b1;
    end else if (wb_cnt_q != '0) begin
      wb_cnt_d = wb_cnt_q - WB_W'(1);
    end
  end

  always_comb begin
    bt_cnt_d   = bt_cnt_q;
    bt_armed_d = bt_armed_q;
    if (bt_start) begin
      bt_cnt_d   = BT_W'(BEACON_TO_CYC);
      bt_armed_d = 1'b1;
    end else if (bt_cnt_q != '0) begin
      bt_cnt_d = bt_cnt_q - BT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge plca_reset_n) begin
    if (!plca_reset_n) begin
      state_q         <= ST_DISABLED;
      aging_q         <= 1'b0;
      local_node_id_q <= ID_UNASSIGNED;
      node_count_q    <= COUNT_MIN;
      pick_fail_q     <= 1'b0;
      wb_cnt_q        <= '0;
      wb_armed_q      <= 1'b0;
      bt_cnt_q        <= '0;
      bt_armed_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      aging_q         <= aging_d;
      local_node_id_q <= local_node_id_d;
      node_count_q    <= node_count_d;
      pick_fail_q     <= pick_fail_d;
      wb_cnt_q        <= wb_cnt_d;
      wb_armed_q      <= wb_armed_d;
      bt_cnt_q        <= bt_cnt_d;
      bt_armed_q      <= bt_armed_d;
    end
  end

  assign state           = state_q;
  assign dplca_aging     = aging_q;
  assign local_node_id   = local_node_id_q;
  assign plca_node_count = node_count_q;
  assign pick_fail       = pick_fail_q;

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef DPLCA_STATS_EN
  logic        stats_clear, coord_entry, loopback_to_evt;
  logic [15:0] coord_entries_q, coord_entries_d;
  logic [15:0] follower_repicks_q, follower_repicks_d;
  logic [15:0] loopback_timeouts_q, loopback_timeouts_d;

  assign stats_clear     = entering && (state_d == ST_DISABLED);
  assign coord_entry     = entering && (state_d == ST_COORDINATOR);
  assign loopback_to_evt = enabled && (state_q == ST_LOOPBACK_TX) && bt_done;

  assign coord_entries_d     = stat_next(coord_entries_q, stats_clear, coord_entry);
  assign follower_repicks_d  = stat_next(follower_repicks_q, stats_clear, repick);
  assign loopback_timeouts_d = stat_next(loopback_timeouts_q, stats_clear, loopback_to_evt);

  always_ff @(posedge clk or negedge plca_reset_n) begin
    if (!plca_reset_n) begin
      coord_entries_q     <= '0;
      follower_repicks_q  <= '0;
      loopback_timeouts_q <= '0;
    end else begin
      coord_entries_q     <= coord_entries_d;
      follower_repicks_q  <= follower_repicks_d;
      loopback_timeouts_q <= loopback_timeouts_d;
    end
  end

  assign coord_entries     = coord_entries_q;
  assign follower_repicks  = follower_repicks_q;
  assign loopback_timeouts = loopback_timeouts_q;
`endif

endmodule
`default_nettype wire
